// File: rtl/vram_dma_if.sv
// ---------------------------------------------------------------------------
// vram_dma_if
// Bus bundle for vram_dma_engine: the Avalon-MM read master port toward the
// HPS-visible SDRAM and the CPU-facing VRAM write port.
//
// Signals:
//   avm_address       32   read byte address            (master -> slave)
//   avm_read          1    read request                 (master -> slave)
//   avm_waitrequest   1    slave stall                  (slave -> master)
//   avm_readdata      128  returned data                (slave -> master)
//   avm_readdatavalid 1    returned data is valid       (slave -> master)
//   vram_wraddr       12   VRAM word address            (master -> slave)
//   vram_wren         1    VRAM write enable            (master -> slave)
//   vram_wrdata       128  VRAM write data              (master -> slave)
//
// Modports: master (the DMA engine), slave (memory / VRAM side).
// ---------------------------------------------------------------------------
interface vram_dma_if;
    logic [31:0]  avm_address;
    logic         avm_read;
    logic         avm_waitrequest;
    logic [127:0] avm_readdata;
    logic         avm_readdatavalid;
    logic [11:0]  vram_wraddr;
    logic         vram_wren;
    logic [127:0] vram_wrdata;

    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output vram_wraddr, vram_wren, vram_wrdata
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  vram_wraddr, vram_wren, vram_wrdata
    );
endinterface

// File: rtl/vram_dma_engine.sv
// ---------------------------------------------------------------------------
// vram_dma_engine
// Avalon-MM read master that copies one full VRAM image (WORDS x 128 bit)
// from SDRAM into the CPU-facing VRAM when the PPU pulses dma_engine_start,
// and returns a one-cycle dma_engine_finish once the last word is written.
//
// Parameters:
//   WORDS        words per transfer (power of two, <= 4096)
//   MAX_PENDING  max accepted-but-unreturned reads (1..64)
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   dma_engine_src_addr    image byte address (bits [3:0] ignored)
//   dma_engine_start       one-cycle start request (ignored while busy)
//   dma_engine_finish      one-cycle completion pulse
//   dma_busy               high from accepted start until finish
//   dma_checksum           XOR of all written 32-bit lanes (0 if disabled)
//   bus                    vram_dma_if.master: Avalon read + VRAM write port
//
// Optional feature: define VRAM_DMA_CHECKSUM_EN to build the checksum;
// otherwise dma_checksum is tied to zero.
// ---------------------------------------------------------------------------
module vram_dma_engine #(
    parameter int WORDS       = 4096,
    parameter int MAX_PENDING = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dma_engine_src_addr,
    input  logic        dma_engine_start,
    output logic        dma_engine_finish,
    output logic        dma_busy,
    output logic [31:0] dma_checksum,
    vram_dma_if.master  bus
);

    localparam int IW = $clog2(WORDS + 1);
    localparam int PW = $clog2(MAX_PENDING + 1);

    localparam logic [IW-1:0] WORDS_N    = IW'(WORDS);
    localparam logic [IW-1:0] LAST_ISSUE = IW'(WORDS - 1);
    localparam logic [PW-1:0] MAXP_N     = PW'(MAX_PENDING);
    localparam logic [11:0]   LAST_ADDR  = 12'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [31:0]     base;
    logic [IW-1:0]   issued;
    logic [PW-1:0]   pending;
    logic [11:0]     wr_cnt;

    logic start_ok;
    logic accept;
    logic rd_ret;
    logic last_wr;

    assign start_ok = (state == IDLE) && dma_engine_start;
    assign accept   = bus.avm_read && !bus.avm_waitrequest;
    // Responses are only meaningful inside a transfer; stragglers that
    // arrive after a reset abort land in IDLE and are dropped here.
    assign rd_ret   = bus.avm_readdatavalid && (state != IDLE);
    assign last_wr  = bus.vram_wren && (bus.vram_wraddr == LAST_ADDR);

    assign dma_busy = (state != IDLE);

    // Request and address are pure functions of registered counters, so they
    // stay put for as long as the slave holds waitrequest.
    assign bus.avm_read    = (state == ISSUE) && (issued < WORDS_N) && (pending < MAXP_N);
    assign bus.avm_address = base + (32'(issued) << 4);

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dma_engine_start)                state_nxt = ISSUE;
            ISSUE:   if (accept && issued == LAST_ISSUE) state_nxt = DRAIN;
            DRAIN:   if (last_wr)                         state_nxt = IDLE;
            default:                                      state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            base              <= '0;
            issued            <= '0;
            pending           <= '0;
            wr_cnt            <= '0;
            dma_engine_finish <= 1'b0;
        end else begin
            state             <= state_nxt;
            dma_engine_finish <= (state == DRAIN) && last_wr;
            if (start_ok) begin
                base    <= dma_engine_src_addr & 32'hFFFF_FFF0;
                issued  <= '0;
                pending <= '0;
                wr_cnt  <= '0;
            end else begin
                if (accept) issued <= issued + IW'(1);
                if (rd_ret) wr_cnt <= wr_cnt + 12'd1;
                case ({accept, rd_ret})
                    2'b10:   pending <= pending + PW'(1);
                    2'b01:   if (pending != '0) pending <= pending - PW'(1);
                    default: ;
                endcase
            end
        end
    end

    // One registered VRAM write per returned word; the port never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vram_wren   <= 1'b0;
            bus.vram_wraddr <= '0;
            bus.vram_wrdata <= '0;
        end else begin
            bus.vram_wren <= rd_ret;
            if (rd_ret) begin
                bus.vram_wraddr <= wr_cnt;
                bus.vram_wrdata <= bus.avm_readdata;
            end
        end
    end

`ifdef VRAM_DMA_CHECKSUM_EN
    logic [31:0] checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (rd_ret) begin
            checksum <= checksum ^ bus.avm_readdata[31:0]  ^ bus.avm_readdata[63:32]
                                 ^ bus.avm_readdata[95:64] ^ bus.avm_readdata[127:96];
        end
    end

    assign dma_checksum = checksum;
`else
    assign dma_checksum = 32'h0;
`endif

endmodule

// File: tb/tb_vram_dma_engine.sv
// ---------------------------------------------------------------------------
// tb_vram_dma_engine
// Self-checking bench for vram_dma_engine. A behavioural memory slave with
// configurable wait states and read latency serves the reads; expected read
// addresses and VRAM writes are queued when a start is issued and popped by
// a monitor whenever the DUT presents a read acceptance, write or finish.
// ---------------------------------------------------------------------------
module tb_vram_dma_engine;

    localparam int WORDS  = 4096;
    localparam int MAXP   = 8;
    localparam int BUDGET = 40000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src = '0;
    logic        start = 1'b0;
    logic        finish;
    logic        busy;
    logic [31:0] checksum;

    vram_dma_if bus();

    vram_dma_engine #(.WORDS(WORDS), .MAX_PENDING(MAXP)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dma_engine_src_addr (src),
        .dma_engine_start    (start),
        .dma_engine_finish   (finish),
        .dma_busy            (busy),
        .dma_checksum        (checksum),
        .bus                 (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic report();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // ---------------- memory contents ----------------
    int          mode = 0;
    logic [31:0] seed = '0;

    function automatic logic [127:0] mem_word(input logic [31:0] a);
        logic [31:0] i, h;
        i = (a >> 4) & 32'hFFF;
        h = (a * 32'h9E37_79B1) ^ seed;
        case (mode)
            0:       return {4{i}};
            1:       return (i == 0) ? {32'h1, 96'h0} : 128'h0;
            default: return {h, h ^ 32'hA5A5_5A5A ^ (a << 3), ~h + a, seed + a * 7};
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [11:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] exp_cs = '0;

    task automatic push_transfer(input logic [31:0] s);
        logic [31:0]  b, a;
        logic [127:0] d;
        b = s & 32'hFFFF_FFF0;
        exp_cs = '0;
        for (int i = 0; i < WORDS; i++) begin
            a = b + 32'(i) * 32'd16;
            d = mem_word(a);
            rd_q.push_back(a);
            wr_q.push_back('{addr: 12'(i), data: d});
`ifdef VRAM_DMA_CHECKSUM_EN
            exp_cs = exp_cs ^ d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
`endif
        end
    endtask

    // ---------------- memory slave ----------------
    typedef struct {
        int           due;
        logic [127:0] data;
    } rsp_t;

    rsp_t rsp_q[$];
    int   wait_cycles = 0;
    int   latency = 1;
    int   wait_left = 0;

    task automatic set_slave(input int w, input int l);
        wait_cycles = w;
        latency = l;
        wait_left = w;
        bus.avm_waitrequest = (w > 0);
    endtask

    initial begin
        logic        acc, stall;
        logic [31:0] a;
        rsp_t        r;
        int          cyc;
        cyc = 0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            acc   = bus.avm_read && !bus.avm_waitrequest;
            stall = bus.avm_read && bus.avm_waitrequest;
            a     = bus.avm_address;
            @(posedge clk);
            cyc++;
            #1;
            if (stall && wait_left > 0) wait_left--;
            if (acc) begin
                rsp_q.push_back('{due: cyc + latency - 1, data: mem_word(a)});
                wait_left = wait_cycles;
            end
            bus.avm_waitrequest = (wait_left > 0);
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = r.data;
            end else begin
                bus.avm_readdatavalid = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit          expect_fin, prev_stall;
        logic [31:0] prev_addr, fin_cs, ea;
        int          outstanding;
        wr_t         w;
        expect_fin = 0; prev_stall = 0; prev_addr = '0; fin_cs = '0; outstanding = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expect_fin = 0; prev_stall = 0; outstanding = 0;
                continue;
            end
            if (expect_fin || finish) begin
                check("finish_pulse", finish, expect_fin);
                if (expect_fin) begin
                    check("busy_in_finish", busy, 0);
                    check("checksum", checksum, fin_cs);
                end
                expect_fin = 0;
            end
            if (bus.vram_wren) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual_addr=%0h required=no_write", bus.vram_wraddr);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", bus.vram_wraddr, w.addr);
                    check("wr_data", bus.vram_wrdata, w.data);
                    if (wr_q.size() == 0) begin
                        expect_fin = 1;
                        fin_cs = exp_cs;
                    end
                end
            end
            if (prev_stall) begin
                check("stall_read_held", bus.avm_read, 1);
                check("stall_addr_held", bus.avm_address, prev_addr);
            end
            prev_stall = bus.avm_read && bus.avm_waitrequest;
            prev_addr  = bus.avm_address;
            if (busy) begin
                if (outstanding >= MAXP) begin
                    check("pending_bound", 32'(outstanding), 32'(MAXP));
                    check("read_at_max_pending", bus.avm_read, 0);
                end
                if (bus.avm_readdatavalid && outstanding > 0) outstanding--;
            end
            if (bus.avm_read && !bus.avm_waitrequest) begin
                outstanding++;
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read actual_addr=%0h required=no_read", bus.avm_address);
                end else begin
                    ea = rd_q.pop_front();
                    check("rd_addr", bus.avm_address, ea);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic start_xfer(input logic [31:0] s);
        push_transfer(s);
        src = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("first_read", bus.avm_read, 1);
        check("first_addr", bus.avm_address, s & 32'hFFFF_FFF0);
    endtask

    task automatic wait_finish();
        int n;
        n = 0;
        while (!finish && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        if (!finish) begin
            errors++;
            $display("FAIL finish_timeout actual=no_finish required=finish_within_%0d", BUDGET);
            report();
        end
        check("reads_left", 32'(rd_q.size()), 0);
        check("writes_left", 32'(wr_q.size()), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_finish"}, finish, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_address"}, bus.avm_address, 0);
        check({tag, "_read"}, bus.avm_read, 0);
        check({tag, "_wraddr"}, bus.vram_wraddr, 0);
        check({tag, "_wren"}, bus.vram_wren, 0);
        check({tag, "_wrdata"}, bus.vram_wrdata, 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        int nwr, nlate, n;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // zero-wait slave, {4{i}} pattern
        set_slave(0, 1); mode = 0;
        start_xfer(32'h3000_0000);
        wait_finish();

        // back-to-back start in the finish cycle, misaligned source
        mode = 1;
        start_xfer(32'h3000_000F);
        wait_finish();

        // three wait states on every read
        @(posedge clk); #1;
        set_slave(3, 1); mode = 0;
        start_xfer(32'h3000_0000);
        wait_finish();

        // read latency 20 saturates the pending window
        @(posedge clk); #1;
        set_slave(0, 20); mode = 2; seed = $urandom;
        start_xfer(32'h3000_0000);
        wait_finish();

        // start pulsed mid-transfer is ignored
        @(posedge clk); #1;
        set_slave(0, 4); mode = 0;
        start_xfer(32'h3000_0000);
        repeat (500) @(posedge clk);
        #1;
        src = 32'h4000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_ignored_start", busy, 1);
        wait_finish();

        // reset after 100 writes, late responses must be dropped
        @(posedge clk); #1;
        set_slave(0, 20); mode = 0;
        start_xfer(32'h3000_0000);
        n = 0;
        while (wr_q.size() > WORDS - 100 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        wr_q.delete();
        rd_q.delete();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_outputs_zero("midreset");
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        nwr = 0; nlate = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.vram_wren) nwr++;
            if (bus.avm_readdatavalid) nlate++;
        end
        check("late_rsp_writes", 32'(nwr), 0);
        check("late_rsp_seen", 32'(nlate > 0), 1);
        start_xfer(32'h3000_0000);
        wait_finish();

        // random slave timing, random source (may wrap past 2^32)
        @(posedge clk); #1;
        set_slave(int'($urandom_range(0, 2)), int'($urandom_range(1, 12)));
        mode = 2; seed = $urandom;
        start_xfer($urandom);
        wait_finish();

        repeat (5) @(posedge clk);
        report();
    end

endmodule
